// File: rtl/fp16_unpacker_pkg.sv
// Shared halffloat definitions: field layout, one-hot class encoding and format constants.
package floatingPoint;

  localparam int unsigned EXP_ALLONES = 31;
  localparam int unsigned BIAS        = 15;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } halffloat;

  // Bit positions of out_class: {nan, inf, denorm, zero, normal}
  typedef enum logic [4:0] {
    FP_NORMAL = 5'b00001,
    FP_ZERO   = 5'b00010,
    FP_DENORM = 5'b00100,
    FP_INF    = 5'b01000,
    FP_NAN    = 5'b10000
  } fpclass_e;

endpackage

// File: rtl/fp16_unpacker_lzc10.sv
// Combinational leading-zero counter for a 10-bit fraction; all-zero input yields 10.
module lzc10 (
  input  logic [9:0] data_i,
  output logic [3:0] count_o
);

  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    count_o = 4'd10;
    for (int unsigned i = 0; i < 10; i++) begin
      if (data_i[i]) count_o = 4'(9 - i);
    end
  end

endmodule

// File: rtl/fp16_unpacker.sv
// Two-stage halffloat decoder: S1 classifies the raw word, S2 produces sign/exponent/significand.
module fp16_unpacker #(
  parameter int unsigned NEXPONENTBITS = 5,
  parameter int unsigned NFRACTIONBITS = 10,
  parameter int unsigned BIAS          = 15
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NEXPONENTBITS+NFRACTIONBITS:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_sign,
  output logic [6:0]                           out_exp,
  output logic [NFRACTIONBITS:0]               out_sig,
  output logic [4:0]                           out_class,
  output logic                                 out_qnan
);

  import floatingPoint::*;

  halffloat  in_word, s1_word_q;
  fpclass_e  in_class, s1_class_q;
  logic      s1_valid_q, s1_valid_d;
  logic      s1_load, s2_adv;
  logic      out_valid_q, out_valid_d;
  logic      out_sign_q;
  logic [6:0]  out_exp_q, exp_d;
  logic [10:0] out_sig_q, sig_d;
  logic [4:0]  out_class_q;
  logic        out_qnan_q, qnan_d;
  logic [3:0]  lz, shift;

  assign in_word = in_data;

  always_comb begin
    in_class = FP_NORMAL;
    if (in_word.exp == '0) begin
      in_class = (in_word.frac == '0) ? FP_ZERO : FP_DENORM;
    end else if (in_word.exp == 5'(EXP_ALLONES)) begin
      in_class = (in_word.frac == '0) ? FP_INF : FP_NAN;
    end
  end

  assign s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)     s1_valid_d = 1'b1;
    else if (s2_adv) s1_valid_d = 1'b0;
    out_valid_d = out_valid_q;
    if (s2_adv)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  lzc10 u_lzc (
    .data_i  (s1_word_q.frac),
    .count_o (lz)
  );

  assign shift = lz + 4'd1;

  always_comb begin
    exp_d  = '0;
    sig_d  = '0;
    qnan_d = 1'b0;
    unique case (s1_class_q)
      FP_NORMAL: begin
        exp_d = {2'b00, s1_word_q.exp} - 7'(BIAS);
        sig_d = {1'b1, s1_word_q.frac};
      end
      // Denormals are renormalised so the leading one lands on bit 10.
      FP_DENORM: begin
        sig_d = {1'b0, s1_word_q.frac} << shift;
        exp_d = -7'd14 - {3'b000, shift};
      end
      FP_NAN: begin
        sig_d  = {1'b0, s1_word_q.frac};
        qnan_d = s1_word_q.frac[9];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_word_q   <= '0;
      s1_class_q  <= FP_ZERO;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_sig_q   <= '0;
      out_class_q <= '0;
      out_qnan_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s1_load) begin
        s1_word_q  <= in_word;
        s1_class_q <= in_class;
      end
      if (s2_adv) begin
        out_sign_q  <= s1_word_q.sign;
        out_exp_q   <= exp_d;
        out_sig_q   <= sig_d;
        out_class_q <= s1_class_q;
        out_qnan_q  <= qnan_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_class = out_class_q;
  assign out_qnan  = out_qnan_q;

endmodule
